// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ram_arb_pkg
// Description : Shared types and constants for the two-port RAM arbiter:
//               FSM state encoding, requester-id constants and the default
//               RAM geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int c_addr_w_def = 3;
    localparam int c_data_w_def = 8;

    localparam logic c_req0 = 1'b0;
    localparam logic c_req1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_rr_grant2.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant2
// Description : Two-way round-robin picker. A lone valid requester always
//               wins; on a tie the requester that was not granted last wins.
// Ports       : valid_i[1:0]  request valid per requester
//               last_grant_i  id of the previously granted requester
//               grant_o       id of the winning requester (meaningful if any_o)
//               any_o         at least one requester is valid
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant2
    import ram_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       any_o
);

    always_comb begin
        grant_o = c_req0;
        case (valid_i)
            2'b01:   grant_o = c_req0;
            2'b10:   grant_o = c_req1;
            2'b11:   grant_o = ~last_grant_i;
            default: grant_o = c_req0;
        endcase
    end

    assign any_o = |valid_i;

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Shares one single-port synchronous RAM (1-cycle registered
//               read) between two requesters with round-robin arbitration.
//               Each transaction runs IDLE -> ISSUE (-> RESP for reads).
// Ports       : clk, rst                 clock, synchronous active-high reset
//               reqN_valid/ready         request handshake (N = 0, 1)
//               reqN_we/addr/wdata       request payload
//               rspN_valid/rdata         one-cycle read response pulse + data
//               ram_en/we/addr/din       registered RAM control outputs
//               ram_dout                 RAM read data
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = c_addr_w_def,
    parameter int DATA_W = c_data_w_def
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    state_t              state_q;
    logic                last_grant_q;
    logic                id_q;
    logic                ram_en_q;
    logic                ram_we_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_din_q;
    logic [1:0]          rsp_valid_q;
    logic [DATA_W-1:0]   rsp0_rdata_q;
    logic [DATA_W-1:0]   rsp1_rdata_q;

    logic                w_grant;
    logic                w_any;
    logic                w_accept;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    rr_grant2 u_rr_grant2 (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (w_grant),
        .any_o        (w_any)
    );

    // Ready is combinational and suppressed during reset so nothing can be
    // considered accepted while the FSM is being forced back to IDLE.
    assign w_accept   = !rst && (state_q == ST_IDLE) && w_any;
    assign req0_ready = w_accept && (w_grant == c_req0);
    assign req1_ready = w_accept && (w_grant == c_req1);

    assign w_sel_we    = (w_grant == c_req1) ? req1_we    : req0_we;
    assign w_sel_addr  = (w_grant == c_req1) ? req1_addr  : req0_addr;
    assign w_sel_wdata = (w_grant == c_req1) ? req1_wdata : req0_wdata;

    // The RAM-side registers double as the latched request: they are loaded
    // at accept and then simply hold, which keeps addr/din stable when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= c_req1;
            id_q         <= c_req0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            rsp_valid_q  <= 2'b00;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        state_q      <= ST_ISSUE;
                        id_q         <= w_grant;
                        last_grant_q <= w_grant;
                        ram_en_q     <= 1'b1;
                        ram_we_q     <= w_sel_we;
                        ram_addr_q   <= w_sel_addr;
                        ram_din_q    <= w_sel_wdata;
                    end
                end
                ST_ISSUE: begin
                    // ram_we_q still carries the latched direction here.
                    state_q  <= ram_we_q ? ST_IDLE : ST_RESP;
                    ram_en_q <= 1'b0;
                    ram_we_q <= 1'b0;
                end
                ST_RESP: begin
                    // RAM output is valid this cycle; capture and route it.
                    state_q           <= ST_IDLE;
                    rsp_valid_q[id_q] <= 1'b1;
                    if (id_q == c_req1) begin
                        rsp1_rdata_q <= ram_dout;
                    end else begin
                        rsp0_rdata_q <= ram_dout;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    ram_en_q <= 1'b0;
                    ram_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule
`default_nettype wire
